// File: rtl/sw_result_collector_pkg.sv
// Shared widths and record layout for the Smith-Waterman result collector.
// The record is the unit stored in the FIFO and shown at the host port.
package sw_result_collector_pkg;

  localparam int CALC_BIT = 16;
  localparam int POS_BIT  = 10;
  localparam int HIT_BIT  = 10;
  localparam int QID_BIT  = 8;

  typedef struct packed {
    logic [QID_BIT-1:0]  qid;
    logic [CALC_BIT-1:0] best;
    logic [POS_BIT-1:0]  pos;
    logic [HIT_BIT-1:0]  hits;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  function automatic int rec_width(
    input int qb, input int cb,
    input int pb, input int hb
  );
    return qb + cb + pb + hb;
  endfunction

endpackage

// File: rtl/sw_result_collector_fifo.sv
// Small synchronous record FIFO with full/empty flags and sync clear.
// A push while full is taken only when a pop happens in the same cycle.
module sw_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             rd;
  logic             wr;

  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd      = pop_i & ~empty_o;
  assign wr      = push_i & (~full_o | rd);
  assign data_o  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (wr && !clear_i) mem[wptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sw_result_collector.sv
// Reduces each query's score stream to one summary record and queues it
// for the host behind a valid/ready port.
module sw_result_collector
  import sw_result_collector_pkg::*;
#(
  parameter int CALC_BIT = sw_result_collector_pkg::CALC_BIT,
  parameter int POS_BIT  = sw_result_collector_pkg::POS_BIT,
  parameter int HIT_BIT  = sw_result_collector_pkg::HIT_BIT,
  parameter int QID_BIT  = sw_result_collector_pkg::QID_BIT,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic [CALC_BIT-1:0] threshold_i,
  input  logic [CALC_BIT-1:0] score_i,
  input  logic                valid_i,
  input  logic                change_q_i,
  output logic                rec_valid_o,
  input  logic                rec_ready_i,
  output logic [QID_BIT-1:0]  rec_qid_o,
  output logic [CALC_BIT-1:0] rec_best_o,
  output logic [POS_BIT-1:0]  rec_pos_o,
  output logic [HIT_BIT-1:0]  rec_hits_o,
  output logic                overflow_o,
  output logic                busy_o
);

  localparam int W = rec_width(QID_BIT, CALC_BIT, POS_BIT, HIT_BIT);
  localparam logic [POS_BIT-1:0] POS_MAX = '1;
  localparam logic [HIT_BIT-1:0] HIT_MAX = '1;

  typedef struct packed {
    logic [QID_BIT-1:0]  qid;
    logic [CALC_BIT-1:0] best;
    logic [POS_BIT-1:0]  pos;
    logic [HIT_BIT-1:0]  hits;
  } crec_t;

  logic [CALC_BIT-1:0] best_r, best_n;
  logic [POS_BIT-1:0]  pos_r, pos_n;
  logic [POS_BIT-1:0]  cnt_r, cnt_n;
  logic [HIT_BIT-1:0]  hits_r, hits_n;
  logic [QID_BIT-1:0]  qid_r, qid_n;
  logic                open_r, open_n;
  logic                ovf_r;
  logic                push;
  logic                pop;
  logic                drop;
  logic                full;
  logic                empty;
  crec_t               rec_in;
  crec_t               head;
  logic [W-1:0]        head_raw;

  // Close uses the accumulators as already updated by a same-cycle score.
  always_comb begin
    best_n = best_r;
    pos_n  = pos_r;
    hits_n = hits_r;
    cnt_n  = cnt_r;
    open_n = open_r;
    qid_n  = qid_r;
    push   = 1'b0;
    rec_in = '0;
    if (valid_i) begin
      if (score_i > best_r) begin
        best_n = score_i;
        pos_n  = cnt_r;
      end
      if (score_i >= threshold_i && hits_r != HIT_MAX)
        hits_n = hits_r + 1'b1;
      if (cnt_r != POS_MAX)
        cnt_n = cnt_r + 1'b1;
      open_n = 1'b1;
    end
    if (change_q_i) begin
      push   = 1'b1;
      rec_in = '{qid: qid_r, best: best_n,
                 pos: pos_n, hits: hits_n};
      best_n = '0;
      pos_n  = '0;
      hits_n = '0;
      cnt_n  = '0;
      open_n = 1'b0;
      qid_n  = qid_r + 1'b1;
    end
  end

  assign pop  = rec_ready_i & ~empty;
  assign drop = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_r <= '0;
      pos_r  <= '0;
      hits_r <= '0;
      cnt_r  <= '0;
      open_r <= 1'b0;
      qid_r  <= '0;
      ovf_r  <= 1'b0;
    end else if (clear_i) begin
      best_r <= '0;
      pos_r  <= '0;
      hits_r <= '0;
      cnt_r  <= '0;
      open_r <= 1'b0;
      qid_r  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      best_r <= best_n;
      pos_r  <= pos_n;
      hits_r <= hits_n;
      cnt_r  <= cnt_n;
      open_r <= open_n;
      qid_r  <= qid_n;
      ovf_r  <= ovf_r | drop;
    end
  end

  sw_rec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (pop),
    .data_o  (head_raw),
    .full_o  (full),
    .empty_o (empty)
  );

  // Head fields read as zero when nothing is queued.
  assign head        = empty ? '0 : crec_t'(head_raw);
  assign rec_valid_o = ~empty;
  assign rec_qid_o   = head.qid;
  assign rec_best_o  = head.best;
  assign rec_pos_o   = head.pos;
  assign rec_hits_o  = head.hits;
  assign overflow_o  = ovf_r;
  assign busy_o      = open_r | ~empty;

endmodule
